// File: rtl/sa_skew_feeder.sv
// Row-vector feeder for the left edge of an M-row systolic array.
// Accepts one M-lane vector per cycle and emits it with lane r delayed r
// cycles relative to lane 0. After the last vector, it drains the skew with
// zero bubbles and pulses done.
module sa_skew_feeder #(
  parameter int unsigned M     = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [64*M-1:0]   in_data,
  output logic [64*M-1:0]   out_left,
  output logic [M-1:0]      out_lane_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned EW         = 64;
  localparam int unsigned FC_W       = (M > 1) ? $clog2(M) : 1;
  // The drain takes M-1 cycles; the counter runs from M-2 down to 0.
  localparam int unsigned FLUSH_LAST = (M > 1) ? (M - 2) : 0;
  localparam bit          HAS_FLUSH  = (M > 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FC_W-1:0]   fc_q, fc_d;
  logic              in_ready_q;
  logic              busy_q;
  logic              done_q, done_d;
  logic              accept_c;

  // A vector is taken only while streaming; in_ready_q mirrors STREAM.
  assign accept_c = in_valid & in_ready_q;

  // Next-state logic: job sequencing, remaining-vector and drain counters.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fc_d    = fc_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The done cycle is still part of the previous job, so start is
        // ignored while done_q is high.
        if (start && !done_q) begin
          if (len != '0) begin
            cnt_d   = len;
            state_d = STREAM;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      STREAM: begin
        if (accept_c) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (HAS_FLUSH) begin
              state_d = FLUSH;
              fc_d    = FC_W'(FLUSH_LAST);
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      FLUSH: begin
        if (fc_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          fc_d = fc_q - FC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and control registers; outputs are decoded from next-state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fc_q       <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fc_q       <= fc_d;
      in_ready_q <= (state_d == STREAM);
      // busy covers the done cycle of a real job but never a len=0 start.
      busy_q     <= (state_d != IDLE) | (done_d & (state_q != IDLE));
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Per-lane delay lines: lane r holds r+1 stages of data and valid.
  for (genvar r = 0; r < M; r++) begin : g_lane
    logic [EW-1:0] d_q [r+1];
    logic          v_q [r+1];

    // Stage 0 injects the accepted element or a zero bubble; later stages shift.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int j = 0; j <= r; j++) begin
          d_q[j] <= '0;
          v_q[j] <= 1'b0;
        end
      end else begin
        d_q[0] <= accept_c ? in_data[EW*r +: EW] : '0;
        v_q[0] <= accept_c;
        for (int j = 1; j <= r; j++) begin
          d_q[j] <= d_q[j-1];
          v_q[j] <= v_q[j-1];
        end
      end
    end

    assign out_left[EW*r +: EW] = d_q[r];
    assign out_lane_valid[r]    = v_q[r];
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Directed bench for sa_skew_feeder with M=3: reset, skew timing, bubbles,
// zero-length jobs, start while busy and reset mid-job.
module tb_sa_skew_feeder;

  localparam int unsigned M     = 3;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned W     = 64 * M;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_data = '0;
  logic [W-1:0]     out_left;
  logic [M-1:0]     out_lane_valid;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  sa_skew_feeder #(.M(M), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .len            (len),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_left       (out_left),
    .out_lane_valid (out_lane_valid),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pack three lanes, lane 0 in the low bits.
  function automatic logic [W-1:0] vec(input logic [63:0] l0, input logic [63:0] l1,
                                       input logic [63:0] l2);
    return {l2, l1, l0};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    len   = CNT_W'($urandom);
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) in_data[32*k +: 32] = $urandom;
    repeat (3) tick();
    checks++; if (out_left !== '0) begin errors++; $display("FAIL rst_out_left: got %h expected 0", out_left); end
    checks++; if (out_lane_valid !== '0) begin errors++; $display("FAIL rst_lane_valid: got %b expected 000", out_lane_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    start = 1'b0;
    in_valid = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({out_left, out_lane_valid, in_ready, busy, done} !== '0) begin
        errors++;
        $display("FAIL post_rst_idle[%0d]: got ready=%b busy=%b done=%b valid=%b data=%h expected all 0",
                 i, in_ready, busy, done, out_lane_valid, out_left);
      end
    end
  endtask

  task automatic test_continuous();
    logic [W-1:0]  v [3];
    logic [63:0]   e0 [6];
    logic [63:0]   e1 [6];
    logic [63:0]   e2 [6];
    logic [W-1:0]  exp_d;
    logic [M-1:0]  exp_v;
    v[0] = vec(64'h11, 64'h12, 64'h13);
    v[1] = vec(64'h21, 64'h22, 64'h23);
    v[2] = vec(64'h31, 64'h32, 64'h33);
    e0 = '{64'h11, 64'h21, 64'h31, 64'h0, 64'h0, 64'h0};
    e1 = '{64'h0, 64'h12, 64'h22, 64'h32, 64'h0, 64'h0};
    e2 = '{64'h0, 64'h0, 64'h13, 64'h23, 64'h33, 64'h0};
    start = 1'b1; len = 16'd3;
    tick();
    start = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL cont_ready_rise: got %b expected 1", in_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cont_busy_rise: got %b expected 1", busy); end
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = (i < 3) ? v[i] : vec(64'hEE, 64'hEE, 64'hEE);
      // Start landing on the edge that closes the done cycle must be ignored.
      if (i == 5) begin start = 1'b1; len = 16'd7; end
      tick();
      exp_d = vec(e0[i], e1[i], e2[i]);
      exp_v = {e2[i] != 0, e1[i] != 0, e0[i] != 0};
      checks++; if (out_left !== exp_d) begin errors++; $display("FAIL cont_data[%0d]: got %h expected %h", i, out_left, exp_d); end
      checks++; if (out_lane_valid !== exp_v) begin errors++; $display("FAIL cont_valid[%0d]: got %b expected %b", i, out_lane_valid, exp_v); end
      checks++; if (done !== (i == 4)) begin errors++; $display("FAIL cont_done[%0d]: got %b expected %b", i, done, i == 4); end
      checks++; if (busy !== (i <= 4)) begin errors++; $display("FAIL cont_busy[%0d]: got %b expected %b", i, busy, i <= 4); end
      checks++; if (in_ready !== (i < 2)) begin errors++; $display("FAIL cont_ready[%0d]: got %b expected %b", i, in_ready, i < 2); end
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_bubble();
    logic [W-1:0]  v [3];
    logic [63:0]   e0 [6];
    logic [63:0]   e1 [6];
    logic [63:0]   e2 [6];
    logic [W-1:0]  exp_d;
    logic [M-1:0]  exp_v;
    v[0] = vec(64'h11, 64'h12, 64'h13);
    v[1] = vec(64'hEE, 64'hEE, 64'hEE);
    v[2] = vec(64'h21, 64'h22, 64'h23);
    e0 = '{64'h11, 64'h0, 64'h21, 64'h0, 64'h0, 64'h0};
    e1 = '{64'h0, 64'h12, 64'h0, 64'h22, 64'h0, 64'h0};
    e2 = '{64'h0, 64'h0, 64'h13, 64'h0, 64'h23, 64'h0};
    // Issued in the cycle right after the previous done cycle.
    start = 1'b1; len = 16'd2;
    tick();
    start = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bub_start_accept: got %b expected 1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      in_valid = (i != 1);
      in_data  = (i < 3) ? v[i] : vec(64'hEE, 64'hEE, 64'hEE);
      tick();
      exp_d = vec(e0[i], e1[i], e2[i]);
      exp_v = {e2[i] != 0, e1[i] != 0, e0[i] != 0};
      checks++; if (out_left !== exp_d) begin errors++; $display("FAIL bub_data[%0d]: got %h expected %h", i, out_left, exp_d); end
      checks++; if (out_lane_valid !== exp_v) begin errors++; $display("FAIL bub_valid[%0d]: got %b expected %b", i, out_lane_valid, exp_v); end
      checks++; if (done !== (i == 4)) begin errors++; $display("FAIL bub_done[%0d]: got %b expected %b", i, done, i == 4); end
      checks++; if (in_ready !== (i < 2)) begin errors++; $display("FAIL bub_ready[%0d]: got %b expected %b", i, in_ready, i < 2); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_len_zero();
    start = 1'b1; len = 16'd0;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL len0_done: got %b expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL len0_ready: got %b expected 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({done, busy, in_ready} !== 3'b000) begin
        errors++;
        $display("FAIL len0_after[%0d]: got done=%b busy=%b ready=%b expected 000", i, done, busy, in_ready);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int n_done = 0;
    start = 1'b1; len = 16'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 2);
      in_data  = (i < 2) ? vec(64'h41 + 64'(i), 64'h0, 64'h0) : vec(64'hEE, 64'hEE, 64'hEE);
      start    = (i == 1) || (i == 2);
      len      = 16'd5;
      tick();
      if (done === 1'b1) n_done++;
      checks++; if (done !== (i == 3)) begin errors++; $display("FAIL sbusy_done[%0d]: got %b expected %b", i, done, i == 3); end
      checks++; if (in_ready !== (i < 1)) begin errors++; $display("FAIL sbusy_ready[%0d]: got %b expected %b", i, in_ready, i < 1); end
    end
    start = 1'b0;
    in_valid = 1'b0;
    checks++; if (n_done != 1) begin errors++; $display("FAIL sbusy_done_count: got %0d expected 1", n_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sbusy_end_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_job();
    logic [W-1:0] exp_d;
    start = 1'b1; len = 16'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = vec(64'hA1, 64'hA2, 64'hA3);
    tick();
    in_data = vec(64'hB1, 64'hB2, 64'hB3);
    tick();
    checks++; if (out_lane_valid !== 3'b011) begin errors++; $display("FAIL mid_pre_valid: got %b expected 011", out_lane_valid); end
    reset = 1'b0;
    #1;
    checks++;
    if ({out_left, out_lane_valid, in_ready, busy, done} !== '0) begin
      errors++;
      $display("FAIL mid_rst_clear: got ready=%b busy=%b done=%b valid=%b data=%h expected all 0",
               in_ready, busy, done, out_lane_valid, out_left);
    end
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({out_left, out_lane_valid, in_ready, busy, done} !== '0) begin
        errors++;
        $display("FAIL mid_post_rst[%0d]: got ready=%b busy=%b done=%b valid=%b data=%h expected all 0",
                 i, in_ready, busy, done, out_lane_valid, out_left);
      end
    end
    start = 1'b1; len = 16'd1;
    tick();
    start = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL k1_ready: got %b expected 1", in_ready); end
    in_valid = 1'b1;
    in_data = vec(64'h51, 64'h52, 64'h53);
    for (int i = 0; i < 4; i++) begin
      tick();
      in_data = vec(64'hEE, 64'hEE, 64'hEE);
      case (i)
        0: exp_d = vec(64'h51, 64'h0, 64'h0);
        1: exp_d = vec(64'h0, 64'h52, 64'h0);
        2: exp_d = vec(64'h0, 64'h0, 64'h53);
        default: exp_d = '0;
      endcase
      checks++; if (out_left !== exp_d) begin errors++; $display("FAIL k1_data[%0d]: got %h expected %h", i, out_left, exp_d); end
      checks++; if (done !== (i == 2)) begin errors++; $display("FAIL k1_done[%0d]: got %b expected %b", i, done, i == 2); end
      checks++; if (busy !== (i <= 2)) begin errors++; $display("FAIL k1_busy[%0d]: got %b expected %b", i, busy, i <= 2); end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_bubble();
    test_len_zero();
    test_start_while_busy();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
